// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NUM_REQ requesters, two grants per cycle.
// Optional conflict counter enabled by defining DPRA_PERF_CNT_EN.
module dpram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
    output logic [DATA_WIDTH-1:0]            data1,
    output logic [ADDR_WIDTH-1:0]            addr1,
    output logic                             enable1,
    input  logic [DATA_WIDTH-1:0]            q1,
    output logic [DATA_WIDTH-1:0]            data2,
    output logic [ADDR_WIDTH-1:0]            addr2,
    output logic                             enable2,
    input  logic [DATA_WIDTH-1:0]            q2
`ifdef DPRA_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]             conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_WIDTH < 1) begin : g_param_check
        $error("dpram_arbiter: unsupported parameter values");
    end

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_next;
    logic             w_a_found, w_b_found, w_hazard_deny;
    logic [IDX_W-1:0] w_a_idx, w_b_idx;

    logic             r_tag1_v, r_tag2_v;
    logic [IDX_W-1:0] r_tag1_idx, r_tag2_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from rr_ptr: first valid -> port 1, next hazard-free valid -> port 2.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_a_found     = 1'b0;
        w_b_found     = 1'b0;
        w_a_idx       = '0;
        w_b_idx       = '0;
        w_hazard_deny = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[wrap_idx(r_rr_ptr, k)]) begin
                if (!w_a_found) begin
                    w_a_found = 1'b1;
                    w_a_idx   = wrap_idx(r_rr_ptr, k);
                end else if (!w_b_found) begin
                    if ((w_addr[wrap_idx(r_rr_ptr, k)] == w_addr[w_a_idx]) &&
                        (req_we[w_a_idx] || req_we[wrap_idx(r_rr_ptr, k)])) begin
                        w_hazard_deny = 1'b1;
                    end else begin
                        w_b_found = 1'b1;
                        w_b_idx   = wrap_idx(r_rr_ptr, k);
                    end
                end
            end
        end
        if (!rst) begin
            w_a_found     = 1'b0;
            w_b_found     = 1'b0;
            w_hazard_deny = 1'b0;
        end
    end

    always_comb begin
        req_gnt = '0;
        addr1   = '0;
        data1   = '0;
        enable1 = 1'b0;
        addr2   = '0;
        data2   = '0;
        enable2 = 1'b0;
        if (w_a_found) begin
            req_gnt[w_a_idx] = 1'b1;
            addr1            = w_addr[w_a_idx];
            enable1          = req_we[w_a_idx];
            if (req_we[w_a_idx]) data1 = w_wdata[w_a_idx];
        end
        if (w_b_found) begin
            req_gnt[w_b_idx] = 1'b1;
            addr2            = w_addr[w_b_idx];
            enable2          = req_we[w_b_idx];
            if (req_we[w_b_idx]) data2 = w_wdata[w_b_idx];
        end
    end

    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_b_found)      w_rr_next = wrap_idx(w_b_idx, 1);
        else if (w_a_found) w_rr_next = wrap_idx(w_a_idx, 1);
    end

    // Tags remember which requester owns each port's read data arriving next cycle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_tag1_v   <= 1'b0;
            r_tag1_idx <= '0;
            r_tag2_v   <= 1'b0;
            r_tag2_idx <= '0;
        end else begin
            r_rr_ptr   <= w_rr_next;
            r_tag1_v   <= w_a_found && !req_we[w_a_idx];
            r_tag1_idx <= w_a_idx;
            r_tag2_v   <= w_b_found && !req_we[w_b_idx];
            r_tag2_idx <= w_b_idx;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (r_tag1_v) begin
            rsp_valid[r_tag1_idx]                           = 1'b1;
            rsp_rdata[r_tag1_idx*DATA_WIDTH +: DATA_WIDTH] = q1;
        end
        if (r_tag2_v) begin
            rsp_valid[r_tag2_idx]                           = 1'b1;
            rsp_rdata[r_tag2_idx*DATA_WIDTH +: DATA_WIDTH] = q2;
        end
    end

`ifdef DPRA_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
        end else if (w_hazard_deny && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
